// File: rtl/tournament_chooser_table.sv
// Tournament chooser: table of saturating counters picking local vs global
// direction prediction per fetch PC, with reset sweep and bypassed lookup.
module tournament_chooser_table #(
   parameter int IDX_BITS = 6,
   parameter int CTR_BITS = 2,
   parameter int USE_GHR  = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lookup_valid,
   input  logic [31:0]         lookup_pc,
   input  logic [IDX_BITS-1:0] lookup_ghr,
   output logic                resp_valid,
   output logic                choose_global,
   input  logic                upd_valid,
   input  logic [31:0]         upd_pc,
   input  logic [IDX_BITS-1:0] upd_ghr,
   input  logic                upd_local_pred,
   input  logic                upd_global_pred,
   input  logic                upd_taken,
   output logic                ready
);
   localparam int N = 1 << IDX_BITS;
   localparam logic [CTR_BITS-1:0] CI = {1'b0, {(CTR_BITS-1){1'b1}}};
   localparam logic [CTR_BITS-1:0] CMAX = '1;
   localparam logic [IDX_BITS-1:0] GMASK = (USE_GHR != 0) ? '1 : '0;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [IDX_BITS-1:0] sweep_q, sweep_d;
   logic [CTR_BITS-1:0] ctr_q [N];
   logic [IDX_BITS-1:0] lk_idx, up_idx, wr_idx;
   logic [CTR_BITS-1:0] up_cur, up_new, wr_val, lk_val;
   logic                lc, gc, inc, dec, upd_en, wr_en;
   logic                unused_pc_bits;

   assign lk_idx = lookup_pc[IDX_BITS+1:2] ^ (lookup_ghr & GMASK);
   assign up_idx = upd_pc[IDX_BITS+1:2] ^ (upd_ghr & GMASK);
   assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                             upd_pc[31:IDX_BITS+2], upd_pc[1:0]};
   assign ready = (state_q == S_RUN);

   // Move the counter toward whichever predictor alone was correct.
   always_comb begin
      lc = (upd_local_pred == upd_taken);
      gc = (upd_global_pred == upd_taken);
      inc = !lc && gc;
      dec = lc && !gc;
      up_cur = ctr_q[up_idx];
      up_new = up_cur;
      if (inc && up_cur != CMAX)
         up_new = up_cur + CTR_BITS'(1);
      else if (dec && up_cur != '0)
         up_new = up_cur - CTR_BITS'(1);
      upd_en = (state_q == S_RUN) && upd_valid && !rst;
   end

   // Next state, sweep pointer and the single table write port.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      wr_en = 1'b0;
      wr_idx = up_idx;
      wr_val = up_new;
      case (state_q)
         S_INIT: begin
            wr_en = 1'b1;
            wr_idx = sweep_q;
            wr_val = CI;
            sweep_d = sweep_q + IDX_BITS'(1);
            if (sweep_q == '1)
               state_d = S_RUN;
         end
         S_RUN: wr_en = upd_en;
         default: state_d = S_INIT;
      endcase
      if (rst) begin
         state_d = S_INIT;
         sweep_d = '0;
         wr_en = 1'b0;
      end
   end

   // Write-first read so a same-cycle update is visible to the lookup.
   always_comb begin
      lk_val = ctr_q[lk_idx];
      if (upd_en && up_idx == lk_idx)
         lk_val = up_new;
   end

   // FSM state and sweep pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // Registered lookup response; choice holds while no response is due.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         choose_global <= 1'b0;
      end else begin
         resp_valid <= lookup_valid;
         if (lookup_valid)
            choose_global <= (state_q == S_RUN) && lk_val[CTR_BITS-1];
      end
   end

   // Counter table storage, one entry written per cycle at most.
   always_ff @(posedge clk) begin
      if (wr_en)
         ctr_q[wr_idx] <= wr_val;
   end
endmodule
